// File: rtl/seg_decode.sv
// seg_decode: reads four active-low 7-segment patterns and rebuilds the
// 14-bit binary value by scanning digits from most to least significant
// with a multiply-by-10 accumulator. Undecodable digits contribute 0 and
// are flagged through ERR / ERR_POS.
module seg_decode (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [7:0]  HEX0,
    input  logic [7:0]  HEX1,
    input  logic [7:0]  HEX2,
    input  logic [7:0]  HEX3,
    output logic        BUSY,
    output logic        DONE,
    output logic [13:0] NUM_OUTPUT,
    output logic        ERR,
    output logic [1:0]  ERR_POS
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    localparam logic [6:0] BLANK = 7'h7F;

    // Map a segment pattern (bits 6:0, active-low) to {is_digit, value}.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            7'h40:   r = {1'b1, 4'd0};
            7'h79:   r = {1'b1, 4'd1};
            7'h24:   r = {1'b1, 4'd2};
            7'h30:   r = {1'b1, 4'd3};
            7'h19:   r = {1'b1, 4'd4};
            7'h12:   r = {1'b1, 4'd5};
            7'h02:   r = {1'b1, 4'd6};
            7'h78:   r = {1'b1, 4'd7};
            7'h00:   r = {1'b1, 4'd8};
            7'h10:   r = {1'b1, 4'd9};
            default: r = {1'b0, 4'd0};
        endcase
        return r;
    endfunction

    // acc*10 as (acc<<3)+(acc<<1) in 17 bits, truncated back to 14 bits.
    function automatic logic [13:0] mul10(input logic [13:0] a);
        logic [16:0] wide;
        wide = ({3'b000, a} << 3) + ({3'b000, a} << 1);
        return wide[13:0];
    endfunction

    logic [0:0]       state;
    logic [3:0][6:0]  hex_lat;   // decimal points are not needed after latching
    logic [13:0]      acc;
    logic [1:0]       cnt;
    logic             seen;      // a non-blank digit has already been scanned
    logic             err_run;
    logic [1:0]       pos_run;

    // Decimal-point bits carry no numeric meaning.
    logic unused_dp;
    assign unused_dp = ^{HEX0[7], HEX1[7], HEX2[7], HEX3[7]};

    logic [6:0]  cur_pat;
    logic [4:0]  cur_dec;
    logic        cur_blank;
    logic        cur_bad;
    logic [13:0] acc_next;
    logic        err_next;
    logic [1:0]  pos_next;

    // Evaluate the digit selected by the counter and the next accumulator value.
    always_comb begin
        cur_pat   = hex_lat[cnt];
        cur_dec   = decode_seg(cur_pat);
        cur_blank = (cur_pat == BLANK);
        // Leading blanks are fine; a blank after any non-blank digit is not.
        cur_bad   = !cur_dec[4] && !(cur_blank && !seen);
        acc_next  = mul10(acc) + (cur_dec[4] ? {10'd0, cur_dec[3:0]} : 14'd0);
        err_next  = err_run | cur_bad;
        pos_next  = (cur_bad && !err_run) ? cnt : pos_run;
    end

    // Control FSM, digit scan and registered result outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            hex_lat    <= '0;
            acc        <= '0;
            cnt        <= '0;
            seen       <= 1'b0;
            err_run    <= 1'b0;
            pos_run    <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            NUM_OUTPUT <= '0;
            ERR        <= 1'b0;
            ERR_POS    <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        hex_lat <= {HEX3[6:0], HEX2[6:0], HEX1[6:0], HEX0[6:0]};
                        acc     <= '0;
                        cnt     <= 2'd3;
                        seen    <= 1'b0;
                        err_run <= 1'b0;
                        pos_run <= '0;
                        BUSY    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    acc     <= acc_next;
                    seen    <= seen | !cur_blank;
                    err_run <= err_next;
                    pos_run <= pos_next;
                    if (cnt == 2'd0) begin
                        NUM_OUTPUT <= acc_next;
                        ERR        <= err_next;
                        ERR_POS    <= err_next ? pos_next : 2'd0;
                        DONE       <= 1'b1;
                        BUSY       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_decode.sv
// Testbench for seg_decode: directed cases from the digit rules plus
// randomized digit mixes checked against a table-driven reference model.
module tb_seg_decode;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [7:0]  HEX0, HEX1, HEX2, HEX3;
    logic        BUSY;
    logic        DONE;
    logic [13:0] NUM_OUTPUT;
    logic        ERR;
    logic [1:0]  ERR_POS;

    int n_vec = 0;
    int n_err = 0;

    seg_decode dut (
        .CLK(CLK), .RST(RST), .START(START),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .BUSY(BUSY), .DONE(DONE), .NUM_OUTPUT(NUM_OUTPUT),
        .ERR(ERR), .ERR_POS(ERR_POS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: read the number digit by digit, most significant first.
    function automatic void model(input logic [7:0] h3, input logic [7:0] h2,
                                  input logic [7:0] h1, input logic [7:0] h0,
                                  output int val, output bit err, output int pos);
        logic [7:0] tbl [10];
        logic [7:0] d [4];
        bit nonblank;
        tbl = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78, 8'h00, 8'h10};
        d = '{h0, h1, h2, h3};
        val = 0; err = 0; pos = 0; nonblank = 0;
        for (int i = 3; i >= 0; i--) begin
            int digit;
            logic [7:0] p;
            p = d[i] & 8'h7F;
            digit = -1;
            for (int k = 0; k < 10; k++) if (tbl[k] == p) digit = k;
            if (digit >= 0) begin
                val = val * 10 + digit;
                nonblank = 1;
            end else if (p == 8'h7F && !nonblank) begin
                val = val * 10;
            end else begin
                val = val * 10;
                if (!err) pos = i;
                err = 1;
                nonblank = 1;
            end
        end
    endfunction

    // One full conversion: start, check four BUSY cycles, then the DONE cycle.
    // Returns at the DONE cycle so a following START lands in that cycle.
    task automatic do_conv(input logic [7:0] a3, input logic [7:0] a2,
                           input logic [7:0] a1, input logic [7:0] a0,
                           input bit scramble, input string tag);
        int ev, ep;
        bit ee;
        model(a3, a2, a1, a0, ev, ee, ep);
        HEX3 = a3; HEX2 = a2; HEX1 = a1; HEX0 = a0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy"}, BUSY, 1);
            check({tag, "_nodone"}, DONE, 0);
            if (scramble) begin
                HEX0 = 8'($urandom); HEX1 = 8'($urandom);
                HEX2 = 8'($urandom); HEX3 = 8'($urandom);
            end
            @(negedge CLK);
        end
        check({tag, "_done"}, DONE, 1);
        check({tag, "_busy_lo"}, BUSY, 0);
        check({tag, "_num"}, NUM_OUTPUT, ev);
        check({tag, "_err"}, ERR, ee);
        check({tag, "_pos"}, ERR_POS, ep);
    endtask

    initial begin
        RST = 1'b1; START = 1'b0;
        HEX0 = 8'hFF; HEX1 = 8'hFF; HEX2 = 8'hFF; HEX3 = 8'hFF;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_num", NUM_OUTPUT, 0);
        check("rst_err", ERR, 0);
        check("rst_pos", ERR_POS, 0);

        // Basic "1234"
        do_conv(8'hF9, 8'hA4, 8'hB0, 8'h99, 0, "v1234");
        check("v1234_lit", NUM_OUTPUT, 1234);
        @(negedge CLK);
        check("v1234_pulse", DONE, 0);

        // Maximum "9999"
        do_conv(8'h90, 8'h90, 8'h90, 8'h90, 0, "v9999");
        check("v9999_lit", NUM_OUTPUT, 14'h270F);

        // Leading blanks, with and without decimal point
        do_conv(8'hFF, 8'hFF, 8'h24, 8'h12, 0, "blank25");
        check("blank25_lit", NUM_OUTPUT, 25);
        do_conv(8'hFF, 8'hFF, 8'h24, 8'h92, 0, "dp25");
        check("dp25_lit", NUM_OUTPUT, 25);
        check("dp25_err", ERR, 0);
        do_conv(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, "allblank");
        check("allblank_lit", NUM_OUTPUT, 0);
        check("allblank_err", ERR, 0);

        // Invalid digits
        do_conv(8'hC0, 8'hC0, 8'h88, 8'hC0, 0, "inv1");
        check("inv1_lit", ERR_POS, 1);
        do_conv(8'hF9, 8'hFF, 8'hC0, 8'hC0, 0, "embblank");
        check("embblank_num", NUM_OUTPUT, 1000);
        check("embblank_pos", ERR_POS, 2);
        do_conv(8'h08, 8'hC0, 8'hC0, 8'h08, 0, "inv30");
        check("inv30_pos", ERR_POS, 3);
        check("inv30_err", ERR, 1);
        @(negedge CLK);

        // START held for 10 cycles: DONE exactly at cycles 5 and 10
        HEX3 = 8'hC0; HEX2 = 8'hF9; HEX1 = 8'hC0; HEX0 = 8'hF8;   // "0107"
        START = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLK);
            if (i == 10) START = 1'b0;
            check($sformatf("held_done_c%0d", i), DONE, (i == 5 || i == 10));
            check($sformatf("held_excl_c%0d", i), BUSY & DONE, 0);
        end
        check("held_num", NUM_OUTPUT, 107);
        @(negedge CLK);

        // HEX inputs scrambled during BUSY
        do_conv(8'hB0, 8'h82, 8'hF8, 8'h80, 1, "scramble");
        check("scramble_lit", NUM_OUTPUT, 3678);
        @(negedge CLK);

        // Reset on the second CONV edge
        HEX3 = 8'hF9; HEX2 = 8'hF9; HEX1 = 8'hF9; HEX0 = 8'h08;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_busy", BUSY, 0);
        check("midrst_done", DONE, 0);
        check("midrst_num", NUM_OUTPUT, 0);
        check("midrst_err", ERR, 0);
        check("midrst_pos", ERR_POS, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("midrst_nodone", DONE, 0);
        end
        do_conv(8'hC0, 8'hC0, 8'h99, 8'hA4, 0, "v0042");
        check("v0042_lit", NUM_OUTPUT, 42);
        @(negedge CLK);

        // RST and START on the same edge
        RST = 1'b1; START = 1'b1;
        @(negedge CLK);
        RST = 1'b0; START = 1'b0;
        check("rststart_busy", BUSY, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("rststart_nodone", DONE, 0);
        end

        // Randomized digit mixes
        for (int n = 0; n < 40; n++) begin
            logic [7:0] h [4];
            logic [7:0] codes [10];
            codes = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78, 8'h00, 8'h10};
            for (int j = 0; j < 4; j++) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r <= 5)      h[j] = codes[$urandom_range(0, 9)] | {$urandom_range(0, 1) == 1, 7'h00};
                else if (r <= 7) h[j] = (r == 6) ? 8'h7F : 8'hFF;
                else             h[j] = 8'($urandom);
            end
            do_conv(h[3], h[2], h[1], h[0], n[0], $sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 1) @(negedge CLK);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg_decode.md
# seg_decode

Sequential decoder that reads four 7-segment display patterns and recovers the 14-bit binary number they show. It is the inverse path of the display chain (binary → BCD → segment patterns). It decodes each digit and rebuilds the value by iterative multiply-by-10 accumulation. It sits in loopback self-check and display-readback paths next to the display driver.

## Interface
- No parameters.
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request conversion; sampled only in IDLE.
- HEX0  in  8  least-significant digit pattern; bit 7 = decimal point, bits 6:0 = segments g..a, active-low.
- HEX1, HEX2, HEX3  in  8 each  next digits up; same encoding as HEX0.
- BUSY  out  1  conversion in progress.
- DONE  out  1  one-cycle pulse: result valid.
- NUM_OUTPUT  out  14  decoded value, 0..9999; holds until next DONE.
- ERR  out  1  last result contained an undecodable digit; updates with NUM_OUTPUT.
- ERR_POS  out  2  index of the most-significant invalid digit in the last result; 0 when ERR=0.

## Operation
- Digit table (bits 6:0; bit 7 ignored): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 hex. Blank = 7F.
- Any other pattern is invalid:
  - It contributes 0 to the value.
  - It sets ERR.
  - ERR_POS records the first invalid digit met, scanning from 3 down to 0.
- Blank is legal only as a leading digit, and then it contributes 0. A blank after a non-blank digit is invalid.
  - An all-blank input yields 0 with ERR=0.
- FSM states:
  - IDLE → CONV on START. On that edge, HEX0..HEX3 are latched, the accumulator is cleared, the digit counter is set to 3, and BUSY is set to 1.
  - CONV → CONV for counter values 3, 2, 1. Each edge applies acc ← acc·10 + d[cnt], then decrements the counter.
  - CONV → IDLE on the counter=0 edge. That edge applies the final accumulate, loads NUM_OUTPUT, ERR and ERR_POS, sets DONE to 1 and BUSY to 0.
- Arithmetic:
  - acc·10 = (acc<<3) + (acc<<1), computed 17 bits wide, with the result truncated to 14 bits.
  - The maximum value 9999 = 0x270F never overflows.
- HEX inputs may change freely after the START edge; only the latched copies are used.
- START while BUSY is ignored, with no queuing.

## Timing
- Reset values: BUSY=0, DONE=0, NUM_OUTPUT=0, ERR=0, ERR_POS=0; FSM in IDLE; accumulator and counter 0.
- Latency: START sampled on edge k → BUSY high after edges k..k+3 → DONE high for exactly the cycle after edge k+4.
  - NUM_OUTPUT, ERR and ERR_POS are valid from that same cycle.
- DONE is a single cycle. The FSM is already in IDLE while DONE is high, so a START in that cycle is accepted.
  - Back-to-back throughput is one result per 5 cycles.
- BUSY and DONE are never high together.
- RST asserted mid-conversion:
  - All outputs and state return to their reset values on that edge.
  - No DONE is produced.
  - The previous NUM_OUTPUT is cleared to 0.
- RST and START high on the same edge: RST wins and the conversion does not start.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Basic value: HEX3..0 = F9, A4, B0, 99 ("1234"), START pulse.
  - Required: BUSY high 4 cycles, then DONE 1 cycle with NUM_OUTPUT=1234, ERR=0.
- Maximum value: all four digits = 90 ("9999").
  - Required: NUM_OUTPUT=0x270F, ERR=0.
- Leading blanks and decimal point: HEX3..0 = FF, FF, 24, 12.
  - Required: NUM_OUTPUT=25, ERR=0.
  - Repeat with HEX0 = 92 (DP lit): required result identical.
  - All-blank input: required NUM_OUTPUT=0, ERR=0.
- Invalid digits:
  - HEX3..0 = C0, C0, 88, C0: required NUM_OUTPUT=0, ERR=1, ERR_POS=1.
  - HEX3..0 = F9, FF, C0, C0 (embedded blank): required NUM_OUTPUT=1000, ERR=1, ERR_POS=2.
  - Invalid at both index 3 and index 0: required ERR_POS=3.
- Handshake:
  - START held high for 10 cycles: required DONE exactly at cycles 5 and 10, i.e. a second conversion accepted in the DONE cycle.
  - Changing HEX inputs during BUSY: required no effect on the result.
- Reset mid-operation: RST pulsed on the 2nd CONV edge.
  - Required: BUSY, DONE, NUM_OUTPUT and ERR all 0, and no DONE follows.
  - Required: a subsequent START with "0042" yields NUM_OUTPUT=42.
